// File: rtl/div_unit_if.sv
// Request/response bundle between the pipeline EX stage and the iterative divider.
// start/op/operands/flush are sampled on the rising clock edge; result is valid while done=1.
interface div_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            done;

  modport master (
    output start, op, operand_a, operand_b, flush,
    input  result, busy, done
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush,
    output result, busy, done
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with a zero-cycle path for divide-by-zero and signed overflow.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  div_unit_if.slave  bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [5:0] CNT_LAST = 6'(XLEN - 1);

  state_e state, state_nxt;

  logic [5:0]      count_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN:0]   div_q;
  logic            rem_sel_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            in_signed;
  logic            in_rem;
  logic            b_zero;
  logic            sgn_ovf;
  logic            fast;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] fast_result;

  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] final_result;
  logic            last;
  logic            busy_c;
  logic            done_c;

  // start is honoured in IDLE and DONE only; a concurrent flush always drops it.
  assign accept    = bus.start && !bus.flush && (state != COMPUTE);
  assign in_signed = ~bus.op[0];
  assign in_rem    = bus.op[1];
  assign b_zero    = (bus.operand_b == '0);
  assign sgn_ovf   = in_signed && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.operand_b == '1);
  assign fast      = b_zero || sgn_ovf;
  assign sa        = in_signed && bus.operand_a[XLEN-1];
  assign sb        = in_signed && bus.operand_b[XLEN-1];
  assign mag_a     = sa ? (-bus.operand_a) : bus.operand_a;
  assign mag_b     = sb ? (-bus.operand_b) : bus.operand_b;

  always_comb begin
    fast_result = '0;
    if (b_zero) begin
      fast_result = in_rem ? bus.operand_a : '1;
    end else begin
      // Signed overflow: quotient is the dividend itself, remainder is zero.
      fast_result = in_rem ? '0 : bus.operand_a;
    end
  end

  // One restoring step on XLEN+1-bit values, so the shifted partial remainder never overflows.
  assign shifted = (rem_q << 1) | {{XLEN{1'b0}}, quo_q[XLEN-1]};
  assign ge      = (shifted >= div_q);
  assign rem_nxt = ge ? (shifted - div_q) : shifted;
  assign quo_nxt = {quo_q[XLEN-2:0], ge};
  assign last    = (count_q == CNT_LAST);

  // Negating zero yields zero, so a zero result never picks up a sign.
  always_comb begin
    final_result = '0;
    if (rem_sel_q) begin
      final_result = neg_r_q ? (-rem_nxt[XLEN-1:0]) : rem_nxt[XLEN-1:0];
    end else begin
      final_result = neg_q_q ? (-quo_nxt) : quo_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = fast ? DONE : COMPUTE;
      end
      COMPUTE: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done_c = 1'b1;
        if (accept) state_nxt = fast ? DONE : COMPUTE;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      if (fast) begin
        result_q <= fast_result;
      end else begin
        count_q   <= '0;
        quo_q     <= mag_a;
        rem_q     <= '0;
        div_q     <= {1'b0, mag_b};
        rem_sel_q <= in_rem;
        neg_q_q   <= sa ^ sb;
        neg_r_q   <= sa;
      end
    end else if (state == COMPUTE && !bus.flush) begin
      count_q <= count_q + 6'd1;
      quo_q   <= quo_nxt;
      rem_q   <= rem_nxt;
      if (last) result_q <= final_result;
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a table of single operations followed by
// hand-written sequences for flush, start collisions, back-to-back and reset.
module tb_div_unit;

  logic       clk;
  logic       reset_n;
  logic [1:0] dbg_state;

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one operation at the current negedge and waits for done (bounded).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt, output logic [31:0] res);
    bus.start     = 1'b1;
    bus.op        = o;
    bus.operand_a = a;
    bus.operand_b = b;
    lat  = 0;
    bcnt = 0;
    res  = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = n;
        res = bus.result;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    int          bcnt;
    int          evts;
    logic [31:0] res;
    logic        done_seen;

    // op encodings: 0 DIV, 1 DIVU, 2 REM, 3 REMU
    vecs[0]  = '{2'd0, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{2'd3, 32'hFFFF_FFFF,  32'h10,         32'hF,          1'b0};
    vecs[3]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[4]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[5]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[6]  = '{2'd2, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1};
    vecs[7]  = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[8]  = '{2'd3, 32'd1234,       32'd0,          32'd1234,       1'b1};
    vecs[9]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    vecs[10] = '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
    vecs[11] = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[12] = '{2'd0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};
    vecs[13] = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[14] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
    vecs[15] = '{2'd0, 32'hFFFF_FFFF,  32'd2,          32'd0,          1'b0};
    vecs[16] = '{2'd2, 32'hFFFF_FFFA,  32'd3,          32'd0,          1'b0};
    vecs[17] = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[18] = '{2'd1, 32'd9,          32'd3,          32'd3,          1'b0};
    vecs[19] = '{2'd3, 32'd1000,       32'd37,         32'd1,          1'b0};

    // ---------------- clock / reset ----------------
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.op        = 2'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_result", bus.result,    32'd0);
    check("rst_state",  32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, res);
      check($sformatf("v%0d_latency", i), 32'(lat),  vecs[i].fast ? 32'd1 : 32'd33);
      check($sformatf("v%0d_result", i),  res,       vecs[i].exp);
      check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), vecs[i].fast ? 32'd0 : 32'd32);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d_hold", i), bus.result, vecs[i].exp);
    end

    // ---------------- start ignored during COMPUTE ----------------
    bus.start = 1'b1; bus.op = 2'd0; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    lat = 0; res = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus.start = (n == 5);
      if (n == 5) begin
        bus.op = 2'd1; bus.operand_a = 32'd9; bus.operand_b = 32'd3;
      end
      if (n == 3) check("cmp_state", 32'(dbg_state), 32'd1);
      if (bus.done) begin
        lat = n; res = bus.result;
        break;
      end
    end
    check("ign_latency", 32'(lat), 32'd33);
    check("ign_result",  res,      32'd14);
    check("done_state",  32'(dbg_state), 32'd2);
    @(negedge clk);

    // ---------------- back-to-back starts accepted in DONE ----------------
    run_op(2'd1, 32'd9, 32'd3, lat, bcnt, res);
    check("b2b0_latency", 32'(lat), 32'd33);
    check("b2b0_result",  res,      32'd3);
    run_op(2'd1, 32'd5, 32'd0, lat, bcnt, res);
    check("b2b1_latency", 32'(lat), 32'd1);
    check("b2b1_result",  res,      32'hFFFF_FFFF);
    run_op(2'd3, 32'hFFFF_FFFF, 32'h10, lat, bcnt, res);
    check("b2b2_latency", 32'(lat), 32'd33);
    check("b2b2_result",  res,      32'hF);
    @(negedge clk);

    // ---------------- flush at cycle 10, new DIVU at cycle 12 ----------------
    bus.start = 1'b1; bus.op = 2'd0; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    done_seen = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) done_seen = 1'b1;
      if (n == 10) begin
        check("fl_busy_c10", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
      end
      if (n == 11) begin
        bus.flush = 1'b0;
        check("fl_busy_c11", 32'(bus.busy), 32'd0);
      end
      if (n == 12) begin
        check("fl_busy_c12", 32'(bus.busy), 32'd0);
        bus.start = 1'b1; bus.op = 2'd1; bus.operand_a = 32'd9; bus.operand_b = 32'd3;
      end
    end
    lat = 0; res = '0;
    for (int n = 13; n <= 60; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        lat = n; res = bus.result;
        break;
      end
    end
    check("fl_no_done",  32'(done_seen), 32'd0);
    check("fl_latency",  32'(lat),       32'd45);
    check("fl_result",   res,            32'd3);
    @(negedge clk);

    // ---------------- flush and start together: start dropped ----------------
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd1; bus.operand_a = 32'd9; bus.operand_b = 32'd3;
    evts = 0;
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      if (bus.busy || bus.done) evts++;
    end
    check("fl_start_dropped", 32'(evts), 32'd0);

    // ---------------- reset mid-operation ----------------
    bus.start = 1'b1; bus.op = 2'd0; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("rs_busy_before", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rs_busy_now",   32'(bus.busy),  32'd0);
    check("rs_done_now",   32'(bus.done),  32'd0);
    check("rs_result_now", bus.result,     32'd0);
    check("rs_state_now",  32'(dbg_state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    evts = 0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (bus.busy || bus.done) evts++;
    end
    check("rs_quiet", 32'(evts), 32'd0);
    run_op(2'd0, 32'd100, 32'd7, lat, bcnt, res);
    check("rs_after_latency", 32'(lat),  32'd33);
    check("rs_after_result",  res,       32'd14);
    check("rs_after_busy",    32'(bcnt), 32'd32);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse, asserted when a divide instruction is in EX.
REQ-005 op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 operand_a  input  XLEN  dividend (rs1).
REQ-007 operand_b  input  XLEN  divisor (rs2).
REQ-008 flush  input  1  abort the in-flight operation (trap/branch flush).
REQ-009 result  output  XLEN  quotient or remainder.
REQ-010 busy  output  1  operation in progress; the hazard detection unit uses this as mul_div_busy.
REQ-011 done  output  1  one-cycle completion pulse; result is valid in the same cycle.

Function
REQ-012 The FSM SHALL have three states: IDLE, COMPUTE, DONE.
REQ-013 In IDLE, start=1 with flush=0 SHALL latch op and the operands, and go to COMPUTE or to DONE per REQ-016.
REQ-014 start SHALL be ignored in COMPUTE; start in DONE SHALL be accepted exactly as in IDLE.
REQ-015 Normal path: restoring radix-2 division on magnitudes, one quotient bit per cycle, 6-bit counter, exactly XLEN cycles in COMPUTE, then DONE.
REQ-016 Fast path, no COMPUTE cycles (start at cycle 0, done at cycle 1):
- divisor zero: DIV/DIVU result all-ones; REM/REMU result operand_a.
- signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
REQ-017 Normal-path latency: start at cycle 0 gives busy=1 in cycles 1..XLEN and done=1 at cycle XLEN+1.
REQ-018 busy SHALL be 1 only in COMPUTE; it SHALL be 0 in IDLE and DONE.
REQ-019 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL return to IDLE unless start is accepted.
REQ-020 Signed ops SHALL use the two's-complement magnitude of each negative operand.
REQ-021 Signed result sign:
- quotient is negated when the operand signs differ;
- remainder takes the sign of the dividend;
- a zero result is never negated.
REQ-022 result SHALL hold its value from done until the next accepted start; it is undefined while busy=1.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge with no done pulse.
REQ-024 flush and start in the same cycle: flush wins and start is dropped.
REQ-025 All arithmetic SHALL be XLEN+1 bits wide internally, so no partial remainder overflows.

Reset
REQ-026 While reset_n=0:
- state is IDLE;
- busy=0, done=0, result=0;
- counter and internal operand registers are 0.
REQ-027 Reset asserted mid-operation SHALL abort immediately (asynchronous) with no done pulse; the first start after deassertion SHALL behave normally.

Verification
REQ-028 DIV 100/7 with start at cycle 0 -> busy=1 in cycles 1..32; done=1 at cycle 33 with result=14.
REQ-029 REM -7 % 2 (0xFFFFFFF9, 2) -> result 0xFFFFFFFF at done.
REQ-030 REMU 0xFFFFFFFF % 0x10 -> result 0xF.
REQ-031 DIVU 5/0 -> done at cycle 1, result 0xFFFFFFFF, busy never 1.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> done at cycle 1, result 0x80000000.
REQ-033 Flush and reset mid-operation:
- DIV 100/7, flush at cycle 10 -> busy=0 from cycle 11, no done; a new DIVU 9/3 at cycle 12 -> done at cycle 45 with result 3.
- reset_n pulsed low at cycle 5 -> busy=0 immediately, no done.
